// File: rtl/sync_seq_pkg.sv
// rtl/sync_seq_pkg.sv - shared types and constants for the sync measurement sequencer
package sync_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WAIT_FIN,
        ST_REPORT,
        ST_ERR
    } state_t;

    localparam int REG_DRIVE_LEN  = 0;
    localparam int REG_SETTLE_LEN = 1;
    localparam int REG_WINDOW_LEN = 2;
    localparam int REG_TIMEOUT    = 3;
    localparam int REG_CTRL       = 4;
    localparam int REG_STATUS     = 5;

    localparam int CTRL_AUTO_BIT  = 0;
    localparam int CTRL_POL_BIT   = 1;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_ERR_BIT   = 1;
    localparam int STAT_DONE_BIT  = 2;

endpackage

// File: rtl/sync_seq_regs.sv
// rtl/sync_seq_regs.sv - config register file, read mux and STATUS clear-on-read (SYNC_SEQ_AUTORERUN_EN)
module sync_seq_regs
    import sync_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cfg_data_in,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              cfg_r,
    input  logic              cfg_w,
    output logic [DATA_W-1:0] cfg_data_out,
    input  logic              busy,
    input  logic              set_done,
    input  logic              set_err,
    output logic [DATA_W-1:0] drive_len,
    output logic [DATA_W-1:0] settle_len,
    output logic [DATA_W-1:0] window_len,
    output logic [DATA_W-1:0] timeout,
    output logic              ctrl_auto,
    output logic              ctrl_pol
);

    logic              stat_done;
    logic              stat_err;
    logic              status_rd;
    logic [DATA_W-1:0] rd_mux;

    assign status_rd = cfg_r && (cfg_addr == ADDR_W'(REG_STATUS));

    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            ADDR_W'(REG_DRIVE_LEN):  rd_mux = drive_len;
            ADDR_W'(REG_SETTLE_LEN): rd_mux = settle_len;
            ADDR_W'(REG_WINDOW_LEN): rd_mux = window_len;
            ADDR_W'(REG_TIMEOUT):    rd_mux = timeout;
            ADDR_W'(REG_CTRL): begin
                rd_mux[CTRL_AUTO_BIT] = ctrl_auto;
                rd_mux[CTRL_POL_BIT]  = ctrl_pol;
            end
            ADDR_W'(REG_STATUS): begin
                rd_mux[STAT_BUSY_BIT] = busy;
                rd_mux[STAT_ERR_BIT]  = stat_err;
                rd_mux[STAT_DONE_BIT] = stat_done;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drive_len    <= '0;
            settle_len   <= '0;
            window_len   <= '0;
            timeout      <= '0;
            ctrl_auto    <= 1'b0;
            ctrl_pol     <= 1'b0;
            stat_done    <= 1'b0;
            stat_err     <= 1'b0;
            cfg_data_out <= '0;
        end else begin
            // rd_mux sees pre-write values, so a same-cycle write is not visible here
            if (cfg_r) begin
                cfg_data_out <= rd_mux;
            end
            if (cfg_w) begin
                case (cfg_addr)
                    ADDR_W'(REG_DRIVE_LEN):  if (!busy) drive_len  <= cfg_data_in;
                    ADDR_W'(REG_SETTLE_LEN): if (!busy) settle_len <= cfg_data_in;
                    ADDR_W'(REG_WINDOW_LEN): if (!busy) window_len <= cfg_data_in;
                    ADDR_W'(REG_TIMEOUT):    if (!busy) timeout    <= cfg_data_in;
                    ADDR_W'(REG_CTRL): begin
                        if (!busy) begin
                            ctrl_auto <= cfg_data_in[CTRL_AUTO_BIT];
                            ctrl_pol  <= cfg_data_in[CTRL_POL_BIT];
                        end
`ifdef SYNC_SEQ_AUTORERUN_EN
                        // while running, only stopping the re-run loop is permitted
                        else if (!cfg_data_in[CTRL_AUTO_BIT]) begin
                            ctrl_auto <= 1'b0;
                        end
`endif
                    end
                    default: ;
                endcase
            end
            // a new event in the same cycle as a clearing read is kept
            stat_done <= (stat_done && !status_rd) || set_done;
            stat_err  <= (stat_err  && !status_rd) || set_err;
        end
    end

endmodule

// File: rtl/sync_seq_ctrl.sv
// rtl/sync_seq_ctrl.sv - drive/settle/sample/wait measurement sequencer (SYNC_SEQ_AUTORERUN_EN: auto re-run)
module sync_seq_ctrl
    import sync_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              top_syncseq_start,
    input  logic [DATA_W-1:0] top_syncseq_cfg_data_in,
    input  logic [ADDR_W-1:0] top_syncseq_cfg_addr,
    input  logic              top_syncseq_cfg_r,
    input  logic              top_syncseq_cfg_w,
    output logic [DATA_W-1:0] syncseq_top_cfg_data_out,
    input  logic              thcomptop_syncseq_finish,
    input  logic [DATA_W-1:0] thcomptop_syncseq_result,
    output logic              syncseq_samplertop_en,
    output logic              syncseq_top_start_data,
    output logic [DATA_W-1:0] syncseq_top_data,
    output logic              syncseq_top_busy,
    output logic              drive_oe,
    output logic              drive_out,
    output logic              sense_oe
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] drive_len, settle_len, window_len, timeout;
    logic              ctrl_auto, ctrl_pol;
    logic              auto_rerun;
    logic [CNT_W-1:0]  timeout_c;

    assign timeout_c = timeout[CNT_W-1:0];

`ifdef SYNC_SEQ_AUTORERUN_EN
    assign auto_rerun = ctrl_auto;
`else
    // the auto bit is kept for readback only
    assign auto_rerun = ctrl_auto & 1'b0;
`endif

    // phases count down to 0; a programmed length of 0 behaves as 1 cycle
    function automatic logic [CNT_W-1:0] load_val(input logic [DATA_W-1:0] len);
        logic [CNT_W-1:0] l;
        l = len[CNT_W-1:0];
        return (l == '0) ? '0 : l - CNT_W'(1);
    endfunction

    sync_seq_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regs (
        .clk          (clk),
        .rst          (rst),
        .cfg_data_in  (top_syncseq_cfg_data_in),
        .cfg_addr     (top_syncseq_cfg_addr),
        .cfg_r        (top_syncseq_cfg_r),
        .cfg_w        (top_syncseq_cfg_w),
        .cfg_data_out (syncseq_top_cfg_data_out),
        .busy         (syncseq_top_busy),
        .set_done     (state == ST_REPORT),
        .set_err      (state == ST_ERR),
        .drive_len    (drive_len),
        .settle_len   (settle_len),
        .window_len   (window_len),
        .timeout      (timeout),
        .ctrl_auto    (ctrl_auto),
        .ctrl_pol     (ctrl_pol)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            syncseq_top_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_WAIT_FIN && thcomptop_syncseq_finish) begin
                syncseq_top_data <= thcomptop_syncseq_result;
            end
        end
    end

    always_comb begin
        state_nxt              = state;
        cnt_nxt                = cnt;
        drive_oe               = 1'b0;
        drive_out              = 1'b0;
        syncseq_samplertop_en  = 1'b0;
        syncseq_top_start_data = 1'b0;
        syncseq_top_busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (top_syncseq_start) begin
                    state_nxt = ST_DRIVE;
                    cnt_nxt   = load_val(drive_len);
                end
            end
            ST_DRIVE: begin
                drive_oe  = 1'b1;
                drive_out = ctrl_pol;
                if (cnt == '0) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = load_val(settle_len);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = ST_SAMPLE;
                    cnt_nxt   = load_val(window_len);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                syncseq_samplertop_en = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_WAIT_FIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_WAIT_FIN: begin
                // finish has priority over a timeout landing in the same cycle
                if (thcomptop_syncseq_finish) begin
                    state_nxt = ST_REPORT;
                end else if (timeout_c != '0 && cnt == timeout_c - CNT_W'(1)) begin
                    state_nxt = ST_ERR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_REPORT, ST_ERR: begin
                syncseq_top_start_data = (state == ST_REPORT);
                state_nxt = ST_IDLE;
                if (auto_rerun) begin
                    state_nxt = ST_DRIVE;
                    cnt_nxt   = load_val(drive_len);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sense_oe = 1'b0;

endmodule

// File: tb/tb_sync_seq_ctrl.sv
// tb/tb_sync_seq_ctrl.sv - scoreboard bench for sync_seq_ctrl
module tb_sync_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_din;
    logic [2:0]  cfg_addr;
    logic        cfg_r;
    logic        cfg_w;
    logic [15:0] cfg_dout;
    logic        finish;
    logic [15:0] result;
    logic        sampler_en;
    logic        start_data;
    logic [15:0] data;
    logic        busy;
    logic        drive_oe;
    logic        drive_out;
    logic        sense_oe;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_rep    = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rd;

    always #5 clk = ~clk;

    sync_seq_ctrl dut (
        .clk                      (clk),
        .rst                      (rst),
        .top_syncseq_start        (start),
        .top_syncseq_cfg_data_in  (cfg_din),
        .top_syncseq_cfg_addr     (cfg_addr),
        .top_syncseq_cfg_r        (cfg_r),
        .top_syncseq_cfg_w        (cfg_w),
        .syncseq_top_cfg_data_out (cfg_dout),
        .thcomptop_syncseq_finish (finish),
        .thcomptop_syncseq_result (result),
        .syncseq_samplertop_en    (sampler_en),
        .syncseq_top_start_data   (start_data),
        .syncseq_top_data         (data),
        .syncseq_top_busy         (busy),
        .drive_oe                 (drive_oe),
        .drive_out                (drive_out),
        .sense_oe                 (sense_oe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard consumer: every result strobe must match the oldest pushed result
    always @(negedge clk) begin
        if (!rst && start_data) begin
            n_rep++;
            if (exp_q.size() == 0) check("unexp_report", start_data, 1'b0);
            else check("report_data", data, exp_q.pop_front());
        end
    end

    task automatic cfg_write(input int addr, input logic [15:0] val);
        cfg_w = 1'b1; cfg_addr = 3'(addr); cfg_din = val;
        @(negedge clk);
        cfg_w = 1'b0;
    endtask

    task automatic cfg_read(input int addr, output logic [15:0] val);
        cfg_r = 1'b1; cfg_addr = 3'(addr);
        @(negedge clk);
        cfg_r = 1'b0;
        val = cfg_dout;
    endtask

    task automatic program_std(input logic [15:0] tmo, input logic [15:0] ctrl);
        cfg_write(0, 16'd3);
        cfg_write(1, 16'd2);
        cfg_write(2, 16'd4);
        cfg_write(3, tmo);
        cfg_write(4, ctrl);
    endtask

    // one measurement with DRIVE=3/SETTLE=2/WINDOW=4 and polarity 1; start is
    // driven in cycle 0, so DRIVE is cycles 1-3 and SAMPLE cycles 6-9
    task automatic run_meas(input int n_cyc, input int fin_cyc, input logic [15:0] res,
                            input int rep_cyc, input int busy_until, input int wr_cyc,
                            input int st2_cyc, input int rst_cyc);
        bit alive;
        start = 1'b1;
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge clk);
            alive = (k <= busy_until);
            check("busy", busy, alive);
            check("drive_oe", drive_oe, alive && k >= 1 && k <= 3);
            check("drive_out", drive_out, alive && k >= 1 && k <= 3);
            check("sampler_en", sampler_en, alive && k >= 6 && k <= 9);
            check("start_data", start_data, k == rep_cyc);
            check("sense_oe", sense_oe, 1'b0);
            start  = (k == st2_cyc);
            finish = (k == fin_cyc);
            result = res;
            if (k == fin_cyc && rep_cyc > 0) exp_q.push_back(res);
            cfg_w    = (k == wr_cyc);
            cfg_addr = 3'd0;
            cfg_din  = 16'd7;
            rst      = (k == rst_cyc);
        end
        start = 1'b0; finish = 1'b0; cfg_w = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_din = '0; cfg_addr = '0;
        cfg_r = 1'b0; cfg_w = 1'b0; finish = 1'b0; result = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", busy, 1'b0);
        check("rst_drive_oe", drive_oe, 1'b0);
        check("rst_sampler", sampler_en, 1'b0);
        check("rst_start_data", start_data, 1'b0);
        check("rst_data", data, 16'h0);
        check("rst_cfg_dout", cfg_dout, 16'h0);
        for (int a = 0; a < 8; a++) begin
            cfg_read(a, rd);
            check($sformatf("rst_reg%0d", a), rd, 16'h0);
        end

        // nominal measurement, finish on the fifth WAIT_FIN cycle
        program_std(16'd0, 16'h2);
        cfg_read(0, rd);
        check("rd_drive_len", rd, 16'd3);
        cfg_read(4, rd);
        check("rd_ctrl", rd, 16'h2);
        cfg_write(6, 16'hffff);
        cfg_read(6, rd);
        check("rd_reg6", rd, 16'h0);
        run_meas(16, 14, 16'h1234, 15, 15, 0, 0, 0);
        check("nom_data", data, 16'h1234);
        check("nom_reports", n_rep, 1);
        cfg_read(5, rd);
        check("status_done", rd, 16'h4);
        cfg_read(5, rd);
        check("status_cleared", rd, 16'h0);

        // timeout after five WAIT_FIN cycles, no report
        cfg_write(3, 16'd5);
        run_meas(17, 0, 16'h0, 0, 15, 0, 0, 0);
        check("tmo_data_held", data, 16'h1234);
        check("tmo_reports", n_rep, 1);
        cfg_read(5, rd);
        check("status_err", rd, 16'h2);
        cfg_read(5, rd);
        check("status_err_clr", rd, 16'h0);

        // write while busy and a second start during SAMPLE are both ignored
        cfg_write(3, 16'd0);
        run_meas(30, 11, 16'hbeef, 12, 12, 2, 7, 0);
        check("busy_reports", n_rep, 2);
        cfg_read(0, rd);
        check("busy_write_ignored", rd, 16'd3);

        // reset during SAMPLE aborts; a later finish does not report
        run_meas(14, 10, 16'hdead, 0, 7, 0, 0, 7);
        check("abort_reports", n_rep, 2);
        check("abort_data", data, 16'h0);
        cfg_read(0, rd);
        check("abort_reg_reset", rd, 16'h0);

`ifdef SYNC_SEQ_AUTORERUN_EN
        // back-to-back runs; clearing auto during run 2 stops after it
        program_std(16'd0, 16'h3);
        start = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            check("auto_busy", busy, k <= 27);
            check("auto_start_data", start_data, k == 15 || k == 27);
            check("auto_drive_oe", drive_oe, (k >= 1 && k <= 3) || (k >= 16 && k <= 18));
            start  = 1'b0;
            finish = (k == 14 || k == 26);
            result = (k == 14) ? 16'h1111 : 16'h2222;
            if (finish) exp_q.push_back(result);
            cfg_w    = (k == 20);
            cfg_addr = 3'd4;
            cfg_din  = 16'h2;
        end
        finish = 1'b0; cfg_w = 1'b0;
        check("auto_reports", n_rep, 4);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sync_seq_ctrl.md
Name: sync_seq_ctrl

Overview:
Measurement sequencer for the sync datapath (sampler -> median -> EMA -> threshold compare). On a start request it drives the line for a programmed pulse, releases it, waits a settle time, opens the sampler window, then waits for the threshold comparator's finish and reports the result upstream. It owns the drive/sense pad enables and a small config register file written through the existing cfg bus.

Parameters:
DATA_W, 16, config/result data width (MSB = DATA_W-1)
ADDR_W, 3, config address width
CNT_W, 16, width of all phase counters (must be <= DATA_W)

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
top_syncseq_start  in  1  one-cycle measurement request
top_syncseq_cfg_data_in  in  DATA_W  config write data
top_syncseq_cfg_addr  in  ADDR_W  config register address
top_syncseq_cfg_r  in  1  config read strobe
top_syncseq_cfg_w  in  1  config write strobe
syncseq_top_cfg_data_out  out  DATA_W  config read data
thcomptop_syncseq_finish  in  1  comparator done pulse
thcomptop_syncseq_result  in  DATA_W  comparator result, valid with finish
syncseq_samplertop_en  out  1  sampler window enable
syncseq_top_start_data  out  1  one-cycle result-valid strobe
syncseq_top_data  out  DATA_W  result, held until next report
syncseq_top_busy  out  1  high in any state except IDLE
drive_oe, drive_out, sense_oe  out  1 each  pad controls

Behaviour:
- Registers (R/W unless noted): 0 DRIVE_LEN, 1 SETTLE_LEN, 2 WINDOW_LEN, 3 TIMEOUT, 4 CTRL (bit0 auto, bit1 drive polarity), 5 STATUS (RO: bit0 busy, bit1 timeout_err, bit2 done; read clears bits 1-2), 6-7 read 0, writes ignored. Writes to 0-4 while busy are ignored; STATUS write ignored.
- Reset: all registers 0; state IDLE; every output 0; syncseq_top_data 0.
- Read: cfg_data_out registered, valid the cycle after cfg_r; holds value otherwise. Simultaneous cfg_r and cfg_w to the same address returns the old value.
- Counter values are used as stored; a length of 0 is treated as 1 cycle.
- FSM:
  IDLE: start (or auto re-run, see option) -> DRIVE; counter loaded.
  DRIVE: drive_oe=1, drive_out=CTRL.bit1, sense_oe=0; after DRIVE_LEN cycles -> SETTLE.
  SETTLE: drive_oe=0; after SETTLE_LEN cycles -> SAMPLE.
  SAMPLE: samplertop_en=1; after WINDOW_LEN cycles -> WAIT_FIN.
  WAIT_FIN: count up; finish -> REPORT; count reaches TIMEOUT (TIMEOUT != 0) -> ERR. TIMEOUT=0 disables the timeout. finish and timeout in the same cycle: finish wins.
  REPORT: data <= captured result, start_data=1 for exactly one cycle, STATUS.done=1 -> IDLE.
  ERR: timeout_err=1, no start_data, data unchanged -> IDLE.
- finish outside WAIT_FIN is ignored. start while busy is ignored (not queued).
- Latency: start at cycle 0 -> DRIVE from cycle 1; start_data asserts 1 cycle after finish is seen.
- sense_oe is always 0 (sense is input-only during a measurement).
- rst mid-operation: abort on the next edge, all outputs to reset values, no report.

Optional Feature:
SYNC_SEQ_AUTORERUN_EN: when defined, CTRL.bit0=1 makes REPORT/ERR return to IDLE and start a new DRIVE on the next cycle without top_syncseq_start, until CTRL.bit0 is cleared (clearing is allowed while busy; it only stops the next re-run). When not defined, CTRL.bit0 is stored but has no effect.

Decomposition:
- Package sync_seq_pkg: state enum, register address constants, STATUS/CTRL bit indices.
- Sub-module sync_seq_regs: register file, read mux and STATUS clear-on-read.
- FSM and counters stay in sync_seq_ctrl.

Test Plan:
- Reset, then read all 8 addresses -> all 0; all outputs 0.
- DRIVE=3, SETTLE=2, WINDOW=4, TIMEOUT=0, start; finish with result 0x1234 five cycles into WAIT_FIN -> drive_oe high cycles 1-3, sampler_en high cycles 6-9, start_data one cycle after finish, data=0x1234, STATUS=0x4 then 0 on re-read.
- TIMEOUT=5, no finish -> ERR after 5 WAIT_FIN cycles, STATUS.bit1=1, no start_data, data unchanged.
- Write DRIVE_LEN while busy; pulse start during SAMPLE -> write ignored, second start ignored, single report.
- Assert rst during SAMPLE -> next cycle all outputs 0, state IDLE, a later finish produces no report.
- With SYNC_SEQ_AUTORERUN_EN, CTRL=1 -> back-to-back measurements with DRIVE restarting the cycle after REPORT; clear CTRL.bit0 -> the current measurement completes and no further run starts.
